// File: rtl/rosc_sampler.sv
// rosc_sampler: samples an asynchronous ring-oscillator bit, removes bias
// with a von Neumann corrector, packs corrected bits into words offered over
// a valid/ack handshake, and runs a repetition-count health test on the
// raw samples.
module rosc_sampler #(
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLE_DIV = 16,
    parameter int RPT_LIMIT  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  rosc_in,
    input  logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  overflow,
    output logic                  error
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int RUN_W = $clog2(RPT_LIMIT + 1);

    typedef enum logic {
        FIRST,
        SECOND
    } pair_t;

    logic                  sync0_reg;
    logic                  sync1_reg;
    logic [DIV_W-1:0]      div_cnt_reg;
    pair_t                 pair_reg;
    logic                  b0_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [DATA_WIDTH-1:0] work_reg;
    logic [RUN_W-1:0]      run_cnt_reg;
    logic                  prev_raw_reg;

    logic                  raw;
    logic                  strobe;
    logic                  emit;
    logic                  complete;
    logic [DATA_WIDTH-1:0] word_next;
    logic [RUN_W-1:0]      run_next;

    // The raw bit is the output of the second synchronizer stage.
    assign raw       = sync1_reg;
    assign strobe    = enable && (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));
    // A corrected bit appears only on the second sample of an unequal pair.
    assign emit      = strobe && (pair_reg == SECOND) && (raw != b0_reg);
    assign word_next = {work_reg[DATA_WIDTH-2:0], b0_reg};
    assign complete  = emit && (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1));

    // Next repetition count: extend a run of identical samples (saturating),
    // or start a new run of length one.
    always_comb begin
        run_next = RUN_W'(1);
        if ((run_cnt_reg != '0) && (raw == prev_raw_reg)) begin
            if (run_cnt_reg == RUN_W'(RPT_LIMIT))
                run_next = run_cnt_reg;
            else
                run_next = run_cnt_reg + RUN_W'(1);
        end
    end

    // Two-flop synchronizer, running regardless of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
        end else begin
            sync0_reg <= rosc_in;
            sync1_reg <= sync0_reg;
        end
    end

    // Sample-strobe divider, held at zero while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt_reg <= '0;
        else if (!enable)
            div_cnt_reg <= '0;
        else if (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1))
            div_cnt_reg <= '0;
        else
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end

    // Von Neumann pair FSM: remember the first sample, judge on the second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_reg <= FIRST;
            b0_reg   <= 1'b0;
        end else if (!enable) begin
            pair_reg <= FIRST;
            b0_reg   <= 1'b0;
        end else if (strobe) begin
            case (pair_reg)
                FIRST: begin
                    b0_reg   <= raw;
                    pair_reg <= SECOND;
                end
                default: pair_reg <= FIRST;
            endcase
        end
    end

    // Word collector: shift corrected bits in from the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= '0;
            work_reg    <= '0;
        end else if (!enable) begin
            bit_cnt_reg <= '0;
            work_reg    <= '0;
        end else if (emit) begin
            if (complete) begin
                bit_cnt_reg <= '0;
                work_reg    <= '0;
            end else begin
                bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                work_reg    <= word_next;
            end
        end
    end

    // Output register and handshake; a word completing while the previous
    // one is still unacknowledged is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (complete && (!data_valid || data_ack)) begin
            data       <= word_next;
            data_valid <= 1'b1;
        end else begin
            if (complete)
                overflow <= 1'b1;
            if (data_ack)
                data_valid <= 1'b0;
        end
    end

    // Repetition-count health test on raw samples; error is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_reg  <= '0;
            prev_raw_reg <= 1'b0;
            error        <= 1'b0;
        end else if (!enable) begin
            run_cnt_reg  <= '0;
            prev_raw_reg <= 1'b0;
        end else if (strobe) begin
            run_cnt_reg  <= run_next;
            prev_raw_reg <= raw;
            if (run_next == RUN_W'(RPT_LIMIT))
                error <= 1'b1;
        end
    end

endmodule

// File: doc/rosc_sampler.md
Name: rosc_sampler

Overview:
Consumer end of the ring-oscillator entropy chain. Samples the asynchronous oscillator output in the clk domain and removes bias with a von Neumann corrector. Packs the corrected bits into DATA_WIDTH-bit words and hands them out through a valid/ack handshake. Also runs a repetition-count health test on the raw samples and raises a sticky error when it fails.

Parameters:
DATA_WIDTH, 32, bits per output word (2..64)
SAMPLE_DIV, 16, clk cycles between raw samples (>=1; 1 = sample every cycle)
RPT_LIMIT, 64, consecutive identical raw samples that trip the health error (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  sampling enable; low = collector idle, output word and handshake kept
rosc_in  input  1  raw ring-oscillator output, asynchronous to clk
data_ack  input  1  consumer accepts data in a cycle where data_valid=1
data  output  DATA_WIDTH  last completed entropy word
data_valid  output  1  data holds an unconsumed word
overflow  output  1  sticky: a completed word was dropped because data_valid was still set
error  output  1  sticky: repetition-count health test failed

Behaviour:
- Reset (async, active-high) clears all state: data=0, data_valid=0, overflow=0, error=0, synchronizer=0, sample counter=0, pair phase=0, bit count=0, run count=0.
- Synchronizer: two flops (sync0, sync1) capture rosc_in on every clk, whatever the value of enable. The raw bit is sync1, so a rosc_in level reaches the raw bit 2 cycles after it is captured.
- Sample strobe:
  - The counter runs 0..SAMPLE_DIV-1 while enable=1.
  - The strobe is a one-cycle pulse when the counter equals SAMPLE_DIV-1; the counter then wraps to 0.
  - With SAMPLE_DIV=1 the strobe is high on every enabled cycle.
- Von Neumann corrector, pair FSM with states FIRST and SECOND, moving on each strobe:
  - FIRST: store the raw bit as b0, go to SECOND.
  - SECOND: compare the raw bit b1 with b0, then go back to FIRST.
  - b0≠b1: emit the corrected bit b0, so (1,0)->1 and (0,1)->0.
  - b0=b1: emit nothing.
- Collector:
  - Each emitted bit is shifted into a working register from the LSB (word = {word[DATA_WIDTH-2:0], bit}) and the bit count increments.
  - When the count reaches DATA_WIDTH, the word completes in that same cycle and the count returns to 0.
  - On completion, if data_valid=0 or data_ack=1 in that cycle: data <= working word and data_valid <= 1 on the next edge. Latency is 1 clk from the strobe of the last bit to data_valid.
  - On completion with data_valid=1 and data_ack=0: the new word is discarded, data and data_valid are unchanged, and overflow <= 1.
- Handshake:
  - data_valid stays high until a cycle with data_ack=1; it clears on the following edge unless a word completes in that same cycle.
  - Ack together with a completion: the new word replaces data and data_valid stays 1, with no overflow.
  - data_ack while data_valid=0 is ignored.
- Health test (raw samples, every strobe):
  - If the raw bit equals the previous raw bit, the run count increments, saturating at RPT_LIMIT; otherwise it is set to 1.
  - When the run count reaches RPT_LIMIT, error <= 1.
  - error stays 1 until reset. Collection and output continue regardless of error.
- enable=0:
  - Sample counter, pair FSM (back to FIRST), bit count, working register and run count are all held at 0, so partial words are discarded.
  - data, data_valid, overflow and error keep their values, and data_ack is still honoured.
  - Re-enabling starts a fresh pair and a fresh word.
- Reset asserted mid-word or mid-handshake aborts immediately to the reset values above. No partial word is ever output.

Test Plan:
1. DATA_WIDTH=8, SAMPLE_DIV=4. After reset, drive raw pairs (1,0),(0,1) alternately for 8 corrected bits -> data_valid rises 1 clk after the 16th strobe, data=8'hAA, overflow=0, error=0.
2. Same setup, with (1,1) and (0,0) pairs interleaved between the valid pairs -> equal pairs emit nothing, data=8'hAA still, and completion is delayed by 4 cycles × (number of equal pairs) × 2 strobes.
3. Hold data_ack=0 while a second word completes -> data keeps the first word, data_valid=1, overflow=1. Pulse data_ack -> data_valid=0 on the next cycle; overflow stays 1.
4. Assert data_ack exactly in the completion cycle of word 2 (SAMPLE_DIV=1) -> data = word 2, data_valid stays 1, overflow=0.
5. RPT_LIMIT=8, rosc_in tied to 1 -> error=1 on the 8th strobe and remains 1 after rosc_in toggles. A von Neumann word still completes later when toggling resumes.
6. enable dropped after 5 of 8 bits, then raised -> the next word needs a full 8 new bits. Async reset pulsed while data_valid=1 -> all outputs read 0 immediately, before the next clk edge.
